// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value chosen per use.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first, rx_valid / frame_err pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 wait_high;
  logic                 rx_s;

  // Line idles high, so the synchroniser powers up as "idle" and never fakes a start bit.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rx_s)
  );

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      // NOTE: the shift register is reset too; it is tiny, and a defined value
      // keeps a partial byte from a previous session out of simulation and equivalence checks.
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          // After a framing error the line may be in break; re-arm only on a high level.
          if (rx_s)
            wait_high <= 1'b0;
          else if (!wait_high)
            state <= START;
        end
        START: begin
          if (cnt == HALF_CNT) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == LAST_IDX)
              state <= STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              wait_high <= 1'b1;
            end
            state <= CLEANUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEANUP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written corner sequences.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  logic [7:0] got_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      got_q.push_back(rx_data);
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (rx_valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  v0, e0;
    bit  seen;

    vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[2] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[4] = '{8'h3C, 1'b0, 0, 1, 8'h80};
    vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

    // Reset with line idle
    #20;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_busy", rx_busy, 0);
    check("reset_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(10);

    // Single 0xA5 frame, with rx_busy timing around the valid pulse
    v0 = valid_cnt; e0 = err_cnt;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (rx_valid) seen = 1'b1;
        end
        check("a5_valid_seen", seen, 1);
        if (seen) begin
          check("a5_rx_data", rx_data, 8'hA5);
          check("a5_busy_at_valid", rx_busy, 1);
          @(negedge clk);
          check("a5_valid_one_cycle", rx_valid, 0);
          check("a5_busy_after_valid", rx_busy, 0);
        end
      end
    join
    idle(20);
    check("a5_valid_count", valid_cnt - v0, 1);
    check("a5_no_frame_err", err_cnt - e0, 0);

    // Back-to-back frames with no idle gap
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("b2b_valid_count", valid_cnt - v0, 2);
    check("b2b_no_frame_err", err_cnt - e0, 0);
    if (valid_cnt - v0 == 2) begin
      check("b2b_first", got_q[v0], 8'hA5);
      check("b2b_second", got_q[v0 + 1], 8'h3C);
    end

    // Start-bit glitch shorter than half a bit
    v0 = valid_cnt; e0 = err_cnt;
    rx_serial = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_serial = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    check("glitch_start_detected", seen, 1);
    idle(30);
    check("glitch_busy_cleared", rx_busy, 0);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_err", err_cnt - e0, 0);
    check("glitch_data_held", rx_data, 8'h3C);

    // Table of single frames with idle gaps
    foreach (vecs[k]) begin
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(vecs[k].data, vecs[k].stop);
      idle(24);
      check($sformatf("vec%0d_valid", k), valid_cnt - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_err", k), err_cnt - e0, vecs[k].exp_err);
      check($sformatf("vec%0d_data", k), rx_data, vecs[k].exp_data);
      check($sformatf("vec%0d_idle", k), rx_busy, 0);
    end

    // Framing error followed by a held-low line (break): no false restart
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    rx_serial = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("break_err_count", err_cnt - e0, 1);
    check("break_no_valid", valid_cnt - v0, 0);
    check("break_not_busy", rx_busy, 0);
    check("break_data_held", rx_data, 8'h5A);
    idle(2 * CPB);
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1);
    idle(24);
    check("after_break_valid", valid_cnt - v0, 1);
    check("after_break_data", rx_data, 8'hC3);

    // Reset in the middle of DATA bit 4 of 0xFF
    v0 = valid_cnt; e0 = err_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (CPB + 4 * CPB + CPB / 2) @(posedge clk);
        #2;
        check("midrst_busy_before", rx_busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_busy", rx_busy, 0);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end
    join
    idle(24);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1);
    idle(24);
    check("post_rst_valid", valid_cnt - v0, 1);
    check("post_rst_data", rx_data, 8'h5A);

    check("valid_and_err_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
